// File: rtl/dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dm_pkg
// Purpose  : Shared encodings for the data-memory access unit: access size
//            codes, the access FSM state type and the kseg0/kseg1 nibble bounds.
// Ports    : (package, no ports)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
package dm_pkg;

    // Access size encoding shared by the MEM-stage request and the bus side.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Top address nibble range covering kseg0 (0x8-0x9) and kseg1 (0xA-0xB).
    localparam logic [3:0] KSEG_LO_NIB = 4'h8;
    localparam logic [3:0] KSEG_HI_NIB = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } dm_state_e;

    // Size code 3 is not a real access size; it behaves as a word.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'd3) ? SZ_WORD : sz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dm_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : dm_lane_align
// Purpose  : Byte-lane steering for the data-memory access unit. Store side
//            replicates right-justified data across the lanes and builds the
//            byte strobes; load side shifts the raw bus word down to the
//            addressed lane and sign/zero-extends bytes and halves.
// Ports    : i_st_size/i_st_lo/i_st_data -> o_st_wdata/o_st_wstrb (store)
//            i_ld_size/i_ld_lo/i_ld_sext/i_ld_raw -> o_ld_data   (load)
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_lo,
    input  logic [31:0] i_st_data,
    output logic [31:0] o_st_wdata,
    output logic [3:0]  o_st_wstrb,
    input  logic [1:0]  i_ld_size,
    input  logic [1:0]  i_ld_lo,
    input  logic        i_ld_sext,
    input  logic [31:0] i_ld_raw,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_shift;

    always_comb begin
        o_st_wdata = i_st_data;
        o_st_wstrb = 4'b1111;
        case (i_st_size)
            SZ_BYTE: begin
                o_st_wdata = {4{i_st_data[7:0]}};
                o_st_wstrb = 4'b0001 << i_st_lo;
            end
            SZ_HALF: begin
                o_st_wdata = {2{i_st_data[15:0]}};
                o_st_wstrb = i_st_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                o_st_wdata = i_st_data;
                o_st_wstrb = 4'b1111;
            end
        endcase
    end

    assign w_ld_shift = i_ld_raw >> {i_ld_lo, 3'b000};

    always_comb begin
        o_ld_data = i_ld_raw;
        case (i_ld_size)
            SZ_BYTE: o_ld_data = {{24{i_ld_sext & w_ld_shift[7]}}, w_ld_shift[7:0]};
            SZ_HALF: o_ld_data = {{16{i_ld_sext & w_ld_shift[15]}}, w_ld_shift[15:0]};
            default: o_ld_data = i_ld_raw;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dm_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : dm_access_unit
// Purpose  : Data-memory interface between the MEM stage and a request /
//            address-ok / data-ok bus. Formats stores and loads, maps kseg0
//            and kseg1 to physical addresses, stalls the pipeline while an
//            access is outstanding and can drop an access on flush.
// Ports    : clk, reset                       - clock, sync active-high reset
//            req_* , flush                    - MEM-stage request side
//            stall, resp_valid, resp_rdata    - pipeline response side
//            err_adel, err_ades               - alignment exceptions
//            data_* (out) / data_*_ok, data_rdata (in) - memory bus
// Options  : DM_ALIGN_CHECK_EN - when defined, misaligned half/word accesses
//            raise err_adel/err_ades and are not issued; when undefined the
//            misaligned low address bits are cleared and the access proceeds.
// Revision : 1.0 - initial release
// ============================================================================
module dm_access_unit
    import dm_pkg::*;
#(
    parameter int          ADDR_W   = 32,
    parameter int unsigned KSEG_MAP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              err_adel,
    output logic              err_ades,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [31:0]       data_wdata,
    output logic [3:0]        data_wstrb,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [31:0]       data_rdata
);

    dm_state_e         r_state;
    dm_state_e         w_state_nxt;
    logic              r_drop;
    logic              w_drop_nxt;
    logic              r_sext;
    logic [1:0]        r_lo;
    logic              r_data_req;
    logic              r_data_wr;
    logic [1:0]        r_data_size;
    logic [ADDR_W-1:0] r_data_addr;
    logic [31:0]       r_data_wdata;
    logic [3:0]        r_data_wstrb;
    logic [31:0]       r_resp_rdata;

    logic [1:0]        w_size;
    logic              w_is_word;
    logic              w_is_half;
    logic              w_err;
    logic [ADDR_W-1:0] w_addr_fix;
    logic [3:0]        w_nib;
    logic [ADDR_W-1:0] w_paddr;
    logic              w_accept;
    logic              w_kill;
    logic              w_capture;
    logic [31:0]       w_st_wdata;
    logic [3:0]        w_st_wstrb;
    logic [31:0]       w_ld_data;

    assign w_size    = norm_size(req_size);
    assign w_is_word = (w_size == SZ_WORD);
    assign w_is_half = (w_size == SZ_HALF);

`ifdef DM_ALIGN_CHECK_EN
    // A misaligned access is refused in IDLE and reported in the same cycle.
    logic w_misalign;
    assign w_misalign = (w_is_half & req_addr[0]) | (w_is_word & (req_addr[1:0] != 2'b00));
    assign w_err      = (r_state == ST_IDLE) & req_valid & ~flush & w_misalign;
    assign w_addr_fix = req_addr;
    assign err_adel   = w_err & ~req_wr;
    assign err_ades   = w_err & req_wr;
`else
    // Without the check, misaligned low bits are silently cleared.
    assign w_err      = 1'b0;
    assign w_addr_fix = {req_addr[ADDR_W-1:2],
                         req_addr[1] & ~w_is_word,
                         req_addr[0] & ~w_is_word & ~w_is_half};
    assign err_adel   = 1'b0;
    assign err_ades   = 1'b0;
`endif

    // kseg0/kseg1 both alias the low 512 MB of physical memory.
    assign w_nib   = w_addr_fix[ADDR_W-1 -: 4];
    assign w_paddr = ((KSEG_MAP != 0) && (w_nib >= KSEG_LO_NIB) && (w_nib <= KSEG_HI_NIB))
                     ? {3'b000, w_addr_fix[ADDR_W-4:0]} : w_addr_fix;

    assign w_accept = (r_state == ST_IDLE) & req_valid & ~flush & ~w_err;

    // A flush arriving together with the final data_ok still discards the data.
    assign w_kill    = r_drop | flush;
    assign w_capture = ~r_data_wr & data_data_ok & ~w_kill &
                       (((r_state == ST_REQ) & data_addr_ok) | (r_state == ST_WAIT));

    dm_lane_align u_lane_align (
        .i_st_size  (w_size),
        .i_st_lo    (w_addr_fix[1:0]),
        .i_st_data  (req_wdata),
        .o_st_wdata (w_st_wdata),
        .o_st_wstrb (w_st_wstrb),
        .i_ld_size  (r_data_size),
        .i_ld_lo    (r_lo),
        .i_ld_sext  (r_sext),
        .i_ld_raw   (data_rdata),
        .o_ld_data  (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                // Once addr_ok is seen the bus owes a data_ok, so a flush can
                // only abandon the request before that point.
                if (data_addr_ok) begin
                    if (!data_data_ok)  w_state_nxt = ST_WAIT;
                    else if (flush)     w_state_nxt = ST_IDLE;
                    else                w_state_nxt = ST_DONE;
                end else if (flush) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (data_data_ok) w_state_nxt = w_kill ? ST_IDLE : ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_drop_nxt = (w_state_nxt == ST_WAIT) & w_kill;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop       <= 1'b0;
            r_sext       <= 1'b0;
            r_lo         <= 2'b00;
            r_data_req   <= 1'b0;
            r_data_wr    <= 1'b0;
            r_data_size  <= 2'b00;
            r_data_addr  <= '0;
            r_data_wdata <= 32'd0;
            r_data_wstrb <= 4'd0;
            r_resp_rdata <= 32'd0;
        end else begin
            r_drop     <= w_drop_nxt;
            r_data_req <= (w_state_nxt == ST_REQ);
            if (w_accept) begin
                r_sext       <= req_sext;
                r_lo         <= w_addr_fix[1:0];
                r_data_wr    <= req_wr;
                r_data_size  <= w_size;
                r_data_addr  <= w_paddr;
                r_data_wdata <= w_st_wdata;
                r_data_wstrb <= req_wr ? w_st_wstrb : 4'd0;
            end
            if (w_capture) r_resp_rdata <= w_ld_data;
        end
    end

    // While a dropped access drains, the pipeline is released.
    assign stall = req_valid & ~flush & (r_state != ST_DONE) & ~w_err & ~r_drop;

    assign resp_valid = (r_state == ST_DONE);
    assign resp_rdata = r_resp_rdata;
    assign data_req   = r_data_req;
    assign data_wr    = r_data_wr;
    assign data_size  = r_data_size;
    assign data_addr  = r_data_addr;
    assign data_wdata = r_data_wdata;
    assign data_wstrb = r_data_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dm_access_unit
// Purpose  : Directed self-checking bench for dm_access_unit.
// Ports    : none
// Options  : DM_ALIGN_CHECK_EN selects the matching alignment expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dm_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_sext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        flush;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err_adel;
    logic        err_ades;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_tests  = 0;
    int n_fail   = 0;
    int resp_cnt = 0;
    int rc;

    dm_access_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_wr       (req_wr),
        .req_size     (req_size),
        .req_sext     (req_sext),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .flush        (flush),
        .stall        (stall),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .err_adel     (err_adel),
        .err_ades     (err_ades),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_wstrb   (data_wstrb),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (resp_valid === 1'b1) resp_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v, input logic wr, input logic [1:0] sz,
                           input logic sx, input logic [31:0] a, input logic [31:0] wd);
        req_valid = v;
        req_wr    = wr;
        req_size  = sz;
        req_sext  = sx;
        req_addr  = a;
        req_wdata = wd;
    endtask

    task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
        data_addr_ok = aok;
        data_data_ok = dok;
        data_rdata   = rd;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
        bus(0, 0, 32'h0);
        repeat (3) step();
        chk("rst_data_req",   {31'd0, data_req},   32'd0);
        chk("rst_data_addr",  data_addr,           32'd0);
        chk("rst_data_wstrb", {28'd0, data_wstrb}, 32'd0);
        chk("rst_data_wdata", data_wdata,          32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata,          32'd0);
        chk("rst_err",        {30'd0, err_adel, err_ades}, 32'd0);
        reset = 1'b0;
        step();

        // Byte store into kseg0, addr_ok and data_ok one cycle apart.
        rc = resp_cnt;
        set_req(1, 1, 2'd0, 0, 32'h8000_0003, 32'h0000_00A5);
        #1;
        chk("sb_stall_idle", {31'd0, stall}, 32'd1);
        step();
        chk("sb_data_req",   {31'd0, data_req},   32'd1);
        chk("sb_data_addr",  data_addr,           32'h0000_0003);
        chk("sb_data_wstrb", {28'd0, data_wstrb}, 32'h8);
        chk("sb_data_wdata", data_wdata,          32'hA5A5_A5A5);
        chk("sb_data_wr",    {31'd0, data_wr},    32'd1);
        bus(1, 0, 32'h0);
        step();
        bus(0, 1, 32'h0);
        #1;
        chk("sb_wait_req_low", {31'd0, data_req}, 32'd0);
        chk("sb_wait_stall",   {31'd0, stall},    32'd1);
        step();
        bus(0, 0, 32'h0);
        #1;
        chk("sb_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("sb_done_stall", {31'd0, stall},      32'd0);
        step();
        set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
        #1;
        chk("sb_resp_pulse", {31'd0, resp_valid}, 32'd0);
        chk("sb_resp_count", resp_cnt - rc,       32'd1);
        chk("sb_rdata_keep", resp_rdata,          32'd0);

        // Signed half load from kseg1, bus answers in one cycle.
        set_req(1, 0, 2'd1, 1, 32'hA000_0002, 32'h0);
        step();
        chk("lhs_data_addr",  data_addr,           32'h0000_0002);
        chk("lhs_data_wstrb", {28'd0, data_wstrb}, 32'h0);
        chk("lhs_data_size",  {30'd0, data_size},  32'd1);
        bus(1, 1, 32'h8001_1234);
        step();
        bus(0, 0, 32'h0);
        set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
        #1;
        chk("lhs_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("lhs_resp_rdata", resp_rdata,          32'hFFFF_8001);
        step();

        // Same load, zero-extended.
        set_req(1, 0, 2'd1, 0, 32'hA000_0002, 32'h0);
        step();
        bus(1, 1, 32'h8001_1234);
        step();
        bus(0, 0, 32'h0);
        set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
        #1;
        chk("lhu_resp_rdata", resp_rdata, 32'h0000_8001);
        step();

        // Slow bus: addr_ok after 5 request cycles, data_ok 3 cycles later.
        rc = resp_cnt;
        set_req(1, 0, 2'd2, 0, 32'h0000_0100, 32'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            bus(i == 4, 0, 32'h0);
            #1;
            chk($sformatf("slow_req_%0d", i),   {31'd0, data_req}, 32'd1);
            chk($sformatf("slow_addr_%0d", i),  data_addr,         32'h0000_0100);
            chk($sformatf("slow_stall_%0d", i), {31'd0, stall},    32'd1);
            step();
        end
        for (int j = 0; j < 3; j++) begin
            bus(0, j == 2, 32'h1234_5678);
            #1;
            chk($sformatf("slow_wreq_%0d", j),   {31'd0, data_req}, 32'd0);
            chk($sformatf("slow_wstall_%0d", j), {31'd0, stall},    32'd1);
            step();
        end
        bus(0, 0, 32'h0);
        #1;
        chk("slow_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("slow_resp_rdata", resp_rdata,          32'h1234_5678);
        chk("slow_done_stall", {31'd0, stall},      32'd0);
        set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
        step();
        chk("slow_resp_count", resp_cnt - rc, 32'd1);

        // Flush while waiting for data: access drains silently.
        rc = resp_cnt;
        set_req(1, 0, 2'd2, 0, 32'h0000_0020, 32'h0);
        step();
        bus(1, 0, 32'h0);
        step();
        bus(0, 0, 32'h0);
        flush = 1'b1;
        #1;
        chk("fl_stall_flush", {31'd0, stall}, 32'd0);
        step();
        flush = 1'b0;
        set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
        bus(0, 1, 32'hCAFE_F00D);
        #1;
        chk("fl_drain_req", {31'd0, data_req}, 32'd0);
        step();
        bus(0, 0, 32'h0);
        set_req(1, 0, 2'd2, 0, 32'h0000_0010, 32'h0);
        #1;
        chk("fl_no_resp",    resp_cnt - rc,  32'd0);
        chk("fl_rdata_keep", resp_rdata,     32'h1234_5678);
        chk("fl_new_stall",  {31'd0, stall}, 32'd1);
        step();
        chk("fl_new_req",  {31'd0, data_req}, 32'd1);
        chk("fl_new_addr", data_addr,         32'h0000_0010);
        bus(1, 1, 32'h5566_7788);
        step();
        bus(0, 0, 32'h0);
        set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
        #1;
        chk("fl_new_rdata", resp_rdata,    32'h5566_7788);
        chk("fl_new_count", resp_cnt - rc, 32'd0);
        step();
        chk("fl_new_count2", resp_cnt - rc, 32'd1);

        // addr_ok and data_ok together, kuseg address is not remapped.
        set_req(1, 0, 2'd2, 0, 32'h1000_0004, 32'h0);
        step();
        chk("lw_data_addr", data_addr, 32'h1000_0004);
        bus(1, 1, 32'hDEAD_BEEF);
        step();
        bus(0, 0, 32'h0);
        set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
        #1;
        chk("lw_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("lw_resp_rdata", resp_rdata,          32'hDEAD_BEEF);
        step();
        chk("lw_addr_hold", data_addr, 32'h1000_0004);

        // Half store to kseg2 (no remap), flushed before addr_ok.
        rc = resp_cnt;
        set_req(1, 1, 2'd1, 0, 32'hC000_0002, 32'h0000_BEEF);
        step();
        chk("sh_data_addr",  data_addr,           32'hC000_0002);
        chk("sh_data_wdata", data_wdata,          32'hBEEF_BEEF);
        chk("sh_data_wstrb", {28'd0, data_wstrb}, 32'hC);
        flush = 1'b1;
        #1;
        chk("sh_flush_stall", {31'd0, stall}, 32'd0);
        step();
        flush = 1'b0;
        set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
        #1;
        chk("sh_flush_req", {31'd0, data_req}, 32'd0);
        step();
        chk("sh_flush_resp", resp_cnt - rc,     32'd0);
        chk("sh_idle_req",   {31'd0, data_req}, 32'd0);

        // Reset in the middle of a request.
        set_req(1, 0, 2'd2, 0, 32'h0000_0040, 32'h0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
        #1;
        chk("mrst_req",   {31'd0, data_req}, 32'd0);
        chk("mrst_addr",  data_addr,         32'd0);
        chk("mrst_rdata", resp_rdata,        32'd0);
        step();

        // Misaligned word load.
        rc = resp_cnt;
        set_req(1, 0, 2'd2, 0, 32'h0000_0006, 32'h0);
        #1;
`ifdef DM_ALIGN_CHECK_EN
        chk("mis_err_adel", {31'd0, err_adel}, 32'd1);
        chk("mis_err_ades", {31'd0, err_ades}, 32'd0);
        chk("mis_stall",    {31'd0, stall},    32'd0);
        step();
        set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
        #1;
        chk("mis_err_pulse", {31'd0, err_adel}, 32'd0);
        chk("mis_no_req",    {31'd0, data_req}, 32'd0);
        step();
        chk("mis_no_resp", resp_cnt - rc, 32'd0);
`else
        chk("mis_err_adel", {31'd0, err_adel}, 32'd0);
        chk("mis_stall",    {31'd0, stall},    32'd1);
        step();
        chk("mis_data_addr", data_addr, 32'h0000_0004);
        bus(1, 1, 32'h1122_3344);
        step();
        bus(0, 0, 32'h0);
        set_req(0, 0, 2'd0, 0, 32'h0, 32'h0);
        #1;
        chk("mis_resp_rdata", resp_rdata, 32'h1122_3344);
        step();
        chk("mis_resp_count", resp_cnt - rc, 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
